// File: rtl/multu_seq_pkg.sv
// Shared types and constants for the iterative unsigned multiplier.
package multu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Iteration counter width; at least one bit so a 1-bit build still elaborates.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/multu_seq_if.sv
// Execute-stage <-> multiplier handshake and result bus.
interface multu_seq_if
    import multu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    modport master (
        output start, abort, a, b,
        input  busy, done, stall, lo, hi
    );

    modport slave (
        input  start, abort, a, b,
        output busy, done, stall, lo, hi
    );
endinterface

// File: rtl/multu_seq_shift_add_step.sv
// One radix-2 shift-and-add iteration on the (2*WIDTH+1)-bit product register.
module shift_add_step
    import multu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH:0]  p_in,
    input  logic [WIDTH-1:0]  mcand,
    output logic [2*WIDTH:0]  p_out
);

    logic [WIDTH:0] upper;

    // Conditional add into the upper half (carry kept in the extra bit), then shift right.
    always_comb begin
        upper = p_in[2*WIDTH:WIDTH];
        if (p_in[0]) begin
            upper = upper + {1'b0, mcand};
        end
        p_out = {upper, p_in[WIDTH-1:0]} >> 1;
    end

endmodule

// File: rtl/multu_seq.sv
// Iterative unsigned multiplier: WIDTH clocks per product, stalls the pipeline while running.
module multu_seq
    import multu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    multu_seq_if.slave   bus
);

    localparam int unsigned    CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              last;
    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic [2*WIDTH:0]  p_q;
    logic [2*WIDTH:0]  p_step;
    logic [CW-1:0]     count_q;

    assign accept = bus.start & ~bus.abort & (state_q != RUN);
    assign last   = (count_q == LAST);

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .p_in  (p_q),
        .mcand (mcand_q),
        .p_out (p_step)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything, including a same-cycle start.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = bus.start ? RUN : IDLE;
                RUN:     state_d = last ? DONE : RUN;
                DONE:    state_d = bus.start ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            p_q     <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (accept) begin
            mcand_q <= bus.a;
            p_q     <= {{(WIDTH + 1){1'b0}}, bus.b};
            count_q <= '0;
        end else if ((state_q == RUN) && !bus.abort) begin
            p_q <= p_step;
            if (last) begin
                hi_q <= p_step[2*WIDTH-1:WIDTH];
                lo_q <= p_step[WIDTH-1:0];
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.stall = (state_q == RUN) | accept;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: doc/multu_seq.md
# multu_seq

Iterative unsigned multiplier for the execute stage, replacing the single-cycle combinational `multu` datapath. It takes `rs`/`rt` operands from the execute stage and produces a 64-bit product as `hi`/`lo`. That result feeds the memory-stage lo/hi registers, which are loaded when `wlh` is asserted. While the multiply runs, the block holds the pipeline with a stall output.

## Interface
- `WIDTH`, default 32: operand width; the product is 2*`WIDTH`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request a multiply of `a`*`b`. Level-sampled.
- `abort` in 1: pipeline flush; cancels an in-flight multiply.
- `a` in `WIDTH`: multiplicand, unsigned.
- `b` in `WIDTH`: multiplier, unsigned.
- `busy` out 1: an iteration is in progress.
- `done` out 1: one-cycle pulse; `hi`/`lo` hold a new result.
- `stall` out 1: hold the F/D/E pipeline registers.
- `lo` out `WIDTH`: product bits [`WIDTH`-1:0].
- `hi` out `WIDTH`: product bits [2*`WIDTH`-1:`WIDTH`].

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE/DONE, `start`=1, `abort`=0: latch `a` into the multiplicand register; load the product register P = {(`WIDTH`+1)'b0, `b`}; set count=0; go to RUN.
  - RUN: each edge, if P[0]=1 add the multiplicand to P[2*`WIDTH`:`WIDTH`] (`WIDTH`+1-bit sum, carry kept); then shift P right by 1; then count++.
  - RUN, last iteration (count=`WIDTH`-1): load `hi`/`lo` from the post-shift P[2*`WIDTH`-1:0]; go to DONE.
  - DONE: lasts exactly one cycle. Goes to RUN if a new start is accepted, else to IDLE.
- Outputs:
  - `busy` = (state==RUN), registered.
  - `done` = (state==DONE), registered.
  - `stall` = `busy` | (`start` & ~`abort` & state!=RUN), combinational.
- `hi`/`lo` change only on the completing edge and hold until the next completion.
- `start` in RUN is ignored; no queueing.
- `abort` is honoured in any state:
  - The next state is IDLE.
  - The partial product is discarded and `hi`/`lo` are left unchanged.
  - `abort` has priority over `start` in the same cycle.
- `reset` forces the state to IDLE immediately (including mid-operation) and clears every register. Reset values: `busy`=0, `done`=0, `stall` = `start`&~`abort` (combinational), `hi`=0, `lo`=0.

## Timing
- Edge 0 is the edge that accepts `start`.
- Edges 1..`WIDTH` perform the iterations; `hi`/`lo` update on edge `WIDTH`.
- `done` is high in the cycle after edge `WIDTH`: latency is `WIDTH` clocks from accept to a visible result (32 for the default).
- `stall` is high from the accept cycle through the last RUN cycle, i.e. `WIDTH`+1 cycles. It is low in the DONE cycle, so the execute-stage instruction advances with the result valid.
- Back-to-back: a `start` in the DONE cycle is accepted, with no idle bubble. The following `done` comes `WIDTH` clocks later.
- The counter is $clog2(`WIDTH`) bits. It never wraps, because completion is detected at `WIDTH`-1.

## Structure
- A shared package holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a default-width constant of 32;
  - the counter-width function.
- One sub-module is natural: `shift_add_step`. It is a combinational (`WIDTH`+1)-bit conditional add plus right shift, and it is reused if a radix-4 variant is built later.
- All other logic (FSM, counter, result registers) stays in `multu_seq`.

## Test plan
- 3 * 5 → `done` exactly 32 clocks after the accept edge; `hi`=0x00000000, `lo`=0x0000000F; `stall` high for 33 cycles.
- 0xFFFFFFFF * 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. This checks carry retention in the (`WIDTH`+1)-bit add.
- 0x12345678 * 0x9ABCDEF0 → `hi`=0x0B00EA4E, `lo`=0x242D2080. Then a `start` pulse at cycle 10 of RUN with different operands → ignored, and the result is unchanged.
- First product 7*6 (`lo`=42). Then start 0x10000*0x10000 and assert `abort` at iteration 12 → IDLE next cycle; no `done`; `hi`/`lo` remain 0/42; `stall` drops immediately.
- Assert `reset` at iteration 20 → `busy`/`done`/`hi`/`lo` are 0 before the next edge. After release, 2*2 completes normally with `lo`=4.
- `start` held high continuously with 1*1, then 2*3 → two `done` pulses 32 clocks apart; `lo`=1, then `lo`=6; no IDLE cycle between them.
